// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide sequencer owning the HI/LO registers.
// One shared 32-iteration shift datapath serves both the shift-add multiply and
// the restoring divide. Signed operations are done on magnitudes, and the signs
// are fixed up in the final FIX cycle.
//
// Ports:
//   clk      core clock
//   resetn   asynchronous active-low reset
//   valid_i  execute-stage op writes HI/LO this cycle
//   op_i     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a_i      rs operand
//   b_i      rt operand
//   rd_i     execute-stage op reads HI/LO (MFHI/MFLO)
//   flush_i  abort any in-flight operation, drop pending MTHI/MTLO
//   hi_o     committed HI (registered)
//   lo_o     committed LO (registered)
//   busy_o   operation in flight
//   stall_o  hold the execute-stage instruction while busy
module muldiv_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        rd_i,
  input  logic        flush_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o
);

  localparam int unsigned CntW = $clog2(ITER);

  localparam logic [2:0] OpMthi = 3'b100;
  localparam logic [2:0] OpMtlo = 3'b101;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              is_div_q;
  logic              neg_res_q;  // negate product / quotient
  logic              neg_rem_q;  // negate remainder
  logic [31:0]       mag_b_q;
  logic [31:0]       acc_hi_q;   // P_hi for multiply, R for divide
  logic [31:0]       acc_lo_q;   // P_lo for multiply, Q for divide
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;

  logic        sign_a;
  logic        sign_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        accept;
  logic [32:0] mul_sum;
  logic [32:0] div_rem;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    // op_i[0] clear selects the signed flavour of MULT/DIV
    sign_a = ~op_i[0] & a_i[31];
    sign_b = ~op_i[0] & b_i[31];
    abs_a  = sign_a ? -a_i : a_i;
    abs_b  = sign_b ? -b_i : b_i;
    // Divide by zero is never started and leaves HI/LO untouched
    accept = valid_i & ~flush_i & ~op_i[2] & (~op_i[1] | (b_i != 32'd0));

    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : 33'd0);

    div_rem  = {acc_hi_q, acc_lo_q[31]};
    div_ge   = (div_rem >= {1'b0, mag_b_q});
    // Only used when div_rem >= mag_b_q, so the 32-bit difference is exact
    div_diff = div_rem[31:0] - mag_b_q;

    prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    quot_fix = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mag_b_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i && op_i == OpMthi) hi_q <= a_i;
          if (valid_i && op_i == OpMtlo) lo_q <= a_i;
          if (accept) begin
            is_div_q  <= op_i[1];
            neg_res_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            mag_b_q   <= abs_b;
            acc_hi_q  <= '0;
            acc_lo_q  <= abs_a;
            cnt_q     <= '0;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          if (is_div_q) begin
            acc_hi_q <= div_ge ? div_diff : div_rem[31:0];
            acc_lo_q <= {acc_lo_q[30:0], div_ge};
          end else begin
            acc_hi_q <= mul_sum[32:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[31:1]};
          end
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(ITER - 1)) state_q <= StFix;
        end
        StFix: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = (state_q != StIdle);
  assign stall_o = busy_o & (valid_i | rd_i);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes the expected HI/LO and busy
// length of each mul/div transaction; a monitor pops and compares on every
// falling edge of busy_o.
module tb_muldiv_unit;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        rd_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        stall_o;

  muldiv_unit #(.ITER(32)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .valid_i (valid_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .rd_i    (rd_i),
    .flush_i (flush_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .stall_o (stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;  // expected busy cycles, 0 = don't check
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.len = len;
    sb_q.push_back(e);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural meaning of each op
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OpMult: begin
        q = sa * sb;
        hi = q[63:32];
        lo = q[31:0];
      end
      OpMultu: begin
        u = {32'd0, a} * {32'd0, b};
        hi = u[63:32];
        lo = u[31:0];
      end
      OpDiv: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
      end
      OpDivu: if (b != 32'd0) begin
        lo = a / b;
        hi = a % b;
      end
      OpMthi: hi = a;
      OpMtlo: lo = a;
      default: ;
    endcase
  endtask

  // Monitor
  logic prev_busy = 1'b0;
  int   blen = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy_o === 1'b1) begin
      blen++;
    end else if (prev_busy) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_completion: got busy fall expected none at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check32("result_hi", hi_o, e.hi);
        check32("result_lo", lo_o, e.lo);
        if (e.len != 0) check32("busy_cycles", 32'(blen), 32'(e.len));
      end
      blen = 0;
    end
    prev_busy = (busy_o === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    op_i = op;
    a_i = a;
    b_i = b;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    step();
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 60) begin
      step();
      n++;
    end
    check32(name, {31'd0, busy_o}, 32'd0);
  endtask

  function automatic logic starts(input logic [2:0] op, input logic [31:0] b);
    return (op <= OpDivu) && !(op[1] && b == 32'd0);
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    model(op, a, b, m_hi, m_lo);
    if (starts(op, b)) begin
      push_exp(m_hi, m_lo, 33);
      issue(op, a, b);
      wait_idle("op_done_timeout");
    end else begin
      issue(op, a, b);
      check32("no_busy_direct_op", {31'd0, busy_o}, 32'd0);
      check32("hi_direct", hi_o, m_hi);
      check32("lo_direct", lo_o, m_lo);
    end
  endtask

  task automatic run_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
    push_exp(eh, el, 33);
    m_hi = eh;
    m_lo = el;
    issue(op, a, b);
    wait_idle("directed_timeout");
  endtask

  function automatic logic [31:0] rand_operand(input logic allow_zero);
    int sel = $urandom_range(0, 5);
    logic [31:0] v;
    case (sel)
      0: v = allow_zero ? 32'd0 : 32'd3;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(1, 40);
      4: v = -$urandom_range(1, 40);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int n;
    logic [31:0] ph;
    logic [31:0] pl;
    logic [2:0]  rop;

    // Reset state
    #1;
    check32("reset_hi", hi_o, 32'd0);
    check32("reset_lo", lo_o, 32'd0);
    check32("reset_busy", {31'd0, busy_o}, 32'd0);
    check32("reset_stall", {31'd0, stall_o}, 32'd0);
    step();
    resetn = 1'b1;
    rd_i = 1'b1;
    step();
    check32("idle_rd_no_stall", {31'd0, stall_o}, 32'd0);
    rd_i = 1'b0;

    // Directed vectors
    run_exp(OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_exp(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_exp(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_exp(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);
    run_exp(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MTHI/MTLO preset, then DIVU by zero is a no-op
    run_op(OpMthi, 32'h11, 32'd0);
    run_op(OpMtlo, 32'h22, 32'd0);
    run_op(OpDivu, 32'd55, 32'd0);
    repeat (3) begin
      step();
      check32("div0_no_busy", {31'd0, busy_o}, 32'd0);
    end
    check32("div0_hi_kept", hi_o, 32'h11);
    check32("div0_lo_kept", lo_o, 32'h22);

    // MFHI two cycles after a MULT stalls until the result is committed
    model(OpMult, 32'd1234567, 32'hFFFF_FF00, m_hi, m_lo);
    push_exp(m_hi, m_lo, 33);
    drive(OpMult, 32'd1234567, 32'hFFFF_FF00);
    @(negedge clk);
    check32("issue_no_stall", {31'd0, stall_o}, 32'd0);
    step();
    valid_i = 1'b0;
    step();
    rd_i = 1'b1;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (!busy_o) break;
      check32("rd_stall_while_busy", {31'd0, stall_o}, 32'd1);
      n++;
    end
    check32("rd_stall_released", {31'd0, stall_o}, 32'd0);
    check32("rd_sees_hi", hi_o, m_hi);
    check32("rd_sees_lo", lo_o, m_lo);
    step();
    rd_i = 1'b0;

    // Back-to-back MULT: second one waits while stalled, then is accepted
    model(OpMult, 32'h8000_0000, 32'h8000_0000, m_hi, m_lo);
    push_exp(m_hi, m_lo, 33);
    model(OpMult, 32'hFFFF_FFF0, 32'd77, m_hi, m_lo);
    push_exp(m_hi, m_lo, 33);
    drive(OpMult, 32'h8000_0000, 32'h8000_0000);
    step();
    drive(OpMult, 32'hFFFF_FFF0, 32'd77);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (!busy_o) break;
      check32("b2b_stall_while_busy", {31'd0, stall_o}, 32'd1);
      n++;
    end
    check32("b2b_no_stall_idle", {31'd0, stall_o}, 32'd0);
    step();
    valid_i = 1'b0;
    check32("b2b_second_accepted", {31'd0, busy_o}, 32'd1);
    wait_idle("b2b_timeout");

    // Flush at CALC counter 10, then DIVU issued as flush drops
    ph = m_hi;
    pl = m_lo;
    push_exp(ph, pl, 11);
    issue(OpDiv, 32'hDEAD_BEEF, 32'd3);
    repeat (10) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check32("flush_busy_low", {31'd0, busy_o}, 32'd0);
    check32("flush_hi_kept", hi_o, ph);
    check32("flush_lo_kept", lo_o, pl);
    run_op(OpDivu, 32'd1000, 32'd33);

    // Flush in the same cycle as valid: nothing accepted, MTHI dropped
    ph = m_hi;
    flush_i = 1'b1;
    issue(OpMult, 32'd9, 32'd9);
    check32("flush_valid_no_busy", {31'd0, busy_o}, 32'd0);
    issue(OpMthi, 32'hCAFE_F00D, 32'd0);
    flush_i = 1'b0;
    check32("flush_mthi_dropped", hi_o, ph);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, rand_operand(1'b1), rand_operand(1'b1));
    end

    // Asynchronous reset mid-CALC
    run_op(OpMthi, 32'h5555_AAAA, 32'd0);
    push_exp(32'd0, 32'd0, 0);
    issue(OpMultu, 32'hFFFF_0000, 32'd12345);
    repeat (5) step();
    #2;
    resetn = 1'b0;
    #1;
    check32("async_reset_hi", hi_o, 32'd0);
    check32("async_reset_lo", lo_o, 32'd0);
    check32("async_reset_busy", {31'd0, busy_o}, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    step();
    resetn = 1'b1;
    step();
    run_op(OpMtlo, 32'h1234, 32'd0);

    repeat (3) step();
    check32("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
